alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 157 +++++++++++++++
 tb/tb_alu_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Command sequencer for an external combinational ALU: IDLE -> EXEC -> RESP with valid/ready handshakes.
// Optional NZCV flags output enabled by defining ALU_SEQUENCER_FLAGS_EN.
module alu_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [1:0]       rsp_op,
    output logic [7:0]       op_count
`ifdef ALU_SEQUENCER_FLAGS_EN
    ,
    output logic [3:0]       rsp_flags
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic             cmd_ready_r;
    logic             rsp_valid_r;
    logic [WIDTH-1:0] alu_a_r;
    logic [WIDTH-1:0] alu_b_r;
    logic [1:0]       alu_ctrl_r;
    logic [WIDTH-1:0] rsp_result_r;
    logic [1:0]       rsp_op_r;
    logic [7:0]       op_count_r;

`ifdef ALU_SEQUENCER_FLAGS_EN
    logic [3:0]       rsp_flags_r;

    // Subtract is A + ~B + 1, so carry-out set means no borrow.
    function automatic logic [3:0] calc_flags(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [1:0]       op,
        input logic [WIDTH-1:0] res
    );
        logic [WIDTH:0] sum;
        logic           c;
        logic           v;
        case (op)
            2'b00: begin
                sum = {1'b0, a} + {1'b0, b};
                c   = sum[WIDTH];
                v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            2'b01: begin
                sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
                c   = sum[WIDTH];
                v   = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            default: begin
                sum = {(WIDTH+1){1'b0}};
                c   = 1'b0;
                v   = 1'b0;
            end
        endcase
        return {res[WIDTH-1], (res == {WIDTH{1'b0}}), c, v};
    endfunction

    assign rsp_flags = rsp_flags_r;
`endif

    // Next-state logic for the three-phase handshake.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_s = ST_EXEC;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_EXEC: state_s = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath registers, handshake outputs and completion counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_ready_r  <= 1'b1;
            rsp_valid_r  <= 1'b0;
            alu_a_r      <= {WIDTH{1'b0}};
            alu_b_r      <= {WIDTH{1'b0}};
            alu_ctrl_r   <= 2'b00;
            rsp_result_r <= {WIDTH{1'b0}};
            rsp_op_r     <= 2'b00;
            op_count_r   <= 8'd0;
`ifdef ALU_SEQUENCER_FLAGS_EN
            rsp_flags_r  <= 4'b0000;
`endif
        end else begin
            cmd_ready_r <= (state_s == ST_IDLE);
            rsp_valid_r <= (state_s == ST_RESP);
            if ((state_r == ST_IDLE) && cmd_valid) begin
                alu_a_r    <= cmd_a;
                alu_b_r    <= cmd_b;
                alu_ctrl_r <= cmd_op;
            end
            if (state_r == ST_EXEC) begin
                rsp_result_r <= alu_result;
                rsp_op_r     <= alu_ctrl_r;
`ifdef ALU_SEQUENCER_FLAGS_EN
                rsp_flags_r  <= calc_flags(alu_a_r, alu_b_r, alu_ctrl_r, alu_result);
`endif
            end
            if ((state_r == ST_RESP) && rsp_ready) begin
                op_count_r <= op_count_r + 8'd1;
            end
        end
    end

    assign cmd_ready  = cmd_ready_r;
    assign rsp_valid  = rsp_valid_r;
    assign alu_a      = alu_a_r;
    assign alu_b      = alu_b_r;
    assign alu_ctrl   = alu_ctrl_r;
    assign rsp_result = rsp_result_r;
    assign rsp_op     = rsp_op_r;
    assign op_count   = op_count_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomised and directed bench for alu_sequencer against a transaction-level reference model.
module tb_alu_sequencer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_op = 2'b00;
    logic [W-1:0] cmd_a = '0;
    logic [W-1:0] cmd_b = '0;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [1:0]   alu_ctrl;
    logic [W-1:0] alu_result;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_result;
    logic [1:0]   rsp_op;
    logic [7:0]   op_count;
`ifdef ALU_SEQUENCER_FLAGS_EN
    logic [3:0]   rsp_flags;
`endif

    int vectors = 0;
    int miscompares = 0;
    logic chk_en = 1'b0;

    alu_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_op(rsp_op), .op_count(op_count)
`ifdef ALU_SEQUENCER_FLAGS_EN
        , .rsp_flags(rsp_flags)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [1:0] op);
        int r;
        case (op)
            2'b00:   r = int'(a) + int'(b);
            2'b01:   r = int'(a) - int'(b);
            2'b10:   r = int'(a & b);
            default: r = int'(a | b);
        endcase
        return r[W-1:0];
    endfunction

    // The external ALU stand-in.
    assign alu_result = ref_alu(alu_a, alu_b, alu_ctrl);

`ifdef ALU_SEQUENCER_FLAGS_EN
    function automatic logic [3:0] ref_flags(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [1:0] op);
        int ua, ub, sa, sb, smax, smin;
        logic [W-1:0] res;
        logic c, v;
        ua = int'(a); ub = int'(b);
        sa = $signed(a); sb = $signed(b);
        smax = (1 << (W-1)) - 1;
        smin = -(1 << (W-1));
        res = ref_alu(a, b, op);
        case (op)
            2'b00: begin
                c = (ua + ub) >= (1 << W);
                v = ((sa + sb) > smax) || ((sa + sb) < smin);
            end
            2'b01: begin
                c = (ua >= ub);
                v = ((sa - sb) > smax) || ((sa - sb) < smin);
            end
            default: begin
                c = 1'b0;
                v = 1'b0;
            end
        endcase
        return {res[W-1], (res == '0), c, v};
    endfunction
`endif

    // Transaction-level reference: one command in flight, result ready the cycle after accept.
    logic         m_busy = 1'b0;
    logic         m_resp = 1'b0;
    logic [W-1:0] m_a = '0, m_b = '0, m_res = '0;
    logic [1:0]   m_op = 2'b00, m_rop = 2'b00;
    logic [7:0]   m_cnt = 8'd0;
`ifdef ALU_SEQUENCER_FLAGS_EN
    logic [3:0]   m_flags = 4'b0000;
`endif

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0; m_resp <= 1'b0;
            m_a <= '0; m_b <= '0; m_op <= 2'b00;
            m_res <= '0; m_rop <= 2'b00; m_cnt <= 8'd0;
`ifdef ALU_SEQUENCER_FLAGS_EN
            m_flags <= 4'b0000;
`endif
        end else if (!m_busy) begin
            if (cmd_valid) begin
                m_busy <= 1'b1;
                m_a <= cmd_a; m_b <= cmd_b; m_op <= cmd_op;
            end
        end else if (!m_resp) begin
            m_resp <= 1'b1;
            m_res  <= ref_alu(m_a, m_b, m_op);
            m_rop  <= m_op;
`ifdef ALU_SEQUENCER_FLAGS_EN
            m_flags <= ref_flags(m_a, m_b, m_op);
`endif
        end else if (rsp_ready) begin
            m_busy <= 1'b0;
            m_resp <= 1'b0;
            m_cnt  <= m_cnt + 8'd1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmd_ready",  {31'd0, cmd_ready}, {31'd0, !m_busy});
            chk("rsp_valid",  {31'd0, rsp_valid}, {31'd0, m_resp});
            chk("alu_a",      32'(alu_a), 32'(m_a));
            chk("alu_b",      32'(alu_b), 32'(m_b));
            chk("alu_ctrl",   32'(alu_ctrl), 32'(m_op));
            chk("rsp_result", 32'(rsp_result), 32'(m_res));
            chk("rsp_op",     32'(rsp_op), 32'(m_rop));
            chk("op_count",   32'(op_count), 32'(m_cnt));
`ifdef ALU_SEQUENCER_FLAGS_EN
            chk("rsp_flags",  32'(rsp_flags), 32'(m_flags));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20 && !cmd_ready; i++) tick();
        chk("wait_ready", {31'd0, cmd_ready}, 32'd1);
    endtask

    task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_res, input logic [3:0] exp_flags);
        wait_ready();
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; rsp_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("lit_latency", {31'd0, rsp_valid}, 32'd1);
        chk("lit_result", 32'(rsp_result), 32'(exp_res));
        chk("lit_op", 32'(rsp_op), 32'(op));
`ifdef ALU_SEQUENCER_FLAGS_EN
        chk("lit_flags", 32'(rsp_flags), 32'(exp_flags));
`else
        if (exp_flags === 4'bxxxx) $display("unexpected flag pattern");
`endif
        tick();
        chk("lit_idle_after", {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        tick();
        tick();
        chk_en = 1'b1;
        rst = 1'b0;
        chk("lit_rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("lit_rst_count", 32'(op_count), 32'd0);
        chk("lit_rst_valid", {31'd0, rsp_valid}, 32'd0);

        // Reset while the response is pending.
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_a = 4'd7; cmd_b = 4'd1; rsp_ready = 1'b0;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("lit_mid_valid_before", {31'd0, rsp_valid}, 32'd1);
        rst = 1'b1; rsp_ready = 1'b1;
        tick();
        rst = 1'b0; rsp_ready = 1'b0;
        chk("lit_mid_valid", {31'd0, rsp_valid}, 32'd0);
        chk("lit_mid_count", 32'(op_count), 32'd0);
        chk("lit_mid_ready", {31'd0, cmd_ready}, 32'd1);

        // Directed arithmetic and logic cases; flags are {N,Z,C,V}.
        do_op(2'b00, 4'd7, 4'd1, 4'h8, 4'b1001);
        chk("lit_count_one", 32'(op_count), 32'd1);
        do_op(2'b01, 4'd3, 4'd5, 4'hE, 4'b1000);
        do_op(2'b01, 4'd5, 4'd5, 4'h0, 4'b0110);
        do_op(2'b10, 4'hC, 4'hA, 4'h8, 4'b1000);
        do_op(2'b11, 4'hC, 4'hA, 4'hE, 4'b1000);
        do_op(2'b00, 4'hF, 4'h1, 4'h0, 4'b0110);

        // Backpressure with a second command held offered.
        wait_ready();
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_a = 4'd9; cmd_b = 4'd3; rsp_ready = 1'b0;
        tick();
        cmd_a = 4'd1; cmd_b = 4'd2; cmd_op = 2'b11;
        tick();
        for (int i = 0; i < 5; i++) tick();
        chk("lit_bp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("lit_bp_ready", {31'd0, cmd_ready}, 32'd0);
        chk("lit_bp_result", 32'(rsp_result), 32'hC);
        chk("lit_bp_alu_a", 32'(alu_a), 32'd9);
        rsp_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("lit_bp_release", {31'd0, cmd_ready}, 32'd1);
        chk("lit_bp_valid_low", {31'd0, rsp_valid}, 32'd0);
        for (int i = 0; i < 4; i++) tick();

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            cmd_valid = ($urandom_range(0, 3) != 0);
            rsp_ready = ($urandom_range(0, 2) != 0);
            cmd_op    = 2'($urandom_range(0, 3));
            cmd_a     = W'($urandom);
            cmd_b     = W'($urandom);
            rst       = ($urandom_range(0, 63) == 0);
            tick();
        end
        rst = 1'b0;

        // Counter wrap over 256 back-to-back operations.
        rst = 1'b1;
        tick();
        rst = 1'b0; cmd_valid = 1'b1; rsp_ready = 1'b1;
        for (int i = 0; i < 2000 && m_cnt != 8'd255; i++) begin
            cmd_op = 2'($urandom_range(0, 3));
            cmd_a  = W'($urandom);
            cmd_b  = W'($urandom);
            tick();
        end
        chk("lit_wrap_255", 32'(op_count), 32'd255);
        for (int i = 0; i < 10 && m_cnt == 8'd255; i++) tick();
        chk("lit_wrap_0", 32'(op_count), 32'd0);
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
